// File: rtl/match_controller_if.sv
// Handshake/status bundle between the Pong match sequencer and its
// neighbours (start button, ball engine, paddle/computer-player datapaths).
interface match_controller_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               start;
  logic [1:0]         diff;
  logic               miss_left;
  logic               miss_right;
  logic               paddle_hit;
  logic               game_on;
  logic               round_reset;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic [1:0]         winner;
  logic               ai_enable;
  logic [31:0]        ai_ticks_per_px;
  logic [2:0]         state_dbg;

  modport master (
    output start, diff, miss_left, miss_right, paddle_hit,
    input  game_on, round_reset, serve_dir, score_left, score_right,
           winner, ai_enable, ai_ticks_per_px, state_dbg
  );

  modport slave (
    input  start, diff, miss_left, miss_right, paddle_hit,
    output game_on, round_reset, serve_dir, score_left, score_right,
           winner, ai_enable, ai_ticks_per_px, state_dbg
  );
endinterface

// File: rtl/match_controller.sv
// Pong match sequencer: serve/play/point/over FSM, scores, computer paddle speed.
// Optional macro RALLY_SPEEDUP_EN: paddle hits in PLAY speed up the computer paddle.
module match_controller #(
  parameter int unsigned SERVE_DELAY = 50000000,
  parameter int unsigned POINT_DELAY = 25000000,
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned TICKS_EASY  = 80000,
  parameter int unsigned TICKS_MED   = 40000,
  parameter int unsigned TICKS_HARD  = 20000,
  parameter int unsigned TICKS_MIN   = 10000,
  parameter int unsigned RALLY_STEP  = 4
) (
  input logic              clk,
  input logic              reset,
  match_controller_if.slave bus
);
  localparam int unsigned DMAX = (SERVE_DELAY > POINT_DELAY) ? SERVE_DELAY : POINT_DELAY;
  localparam int unsigned DW   = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t             state, next_state;
  logic [DW-1:0]      delay_cnt;
  logic               start_q;
  logic [1:0]         diff_q;
  logic               start_rise, any_miss, win_left, win_right;
  logic [SCORE_W-1:0] left_next, right_next;

  function automatic logic [31:0] ticks_for(input logic [1:0] d);
    case (d)
      2'b10:   return 32'(TICKS_MED);
      2'b11:   return 32'(TICKS_HARD);
      default: return 32'(TICKS_EASY);
    endcase
  endfunction

  assign start_rise = bus.start & ~start_q;
  assign any_miss   = bus.miss_left | bus.miss_right;
  // A simultaneous double miss scores for nobody.
  assign left_next  = bus.score_left  + SCORE_W'(bus.miss_right & ~bus.miss_left);
  assign right_next = bus.score_right + SCORE_W'(bus.miss_left & ~bus.miss_right);
  assign win_left   = (left_next == WIN);
  assign win_right  = (right_next == WIN);
  assign bus.state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, OVER: if (start_rise) next_state = SERVE;
      SERVE:      if (delay_cnt == '0) next_state = PLAY;
      PLAY:       if (any_miss) next_state = (win_left || win_right) ? OVER : POINT;
      POINT:      if (delay_cnt == '0) next_state = SERVE;
      default:    next_state = IDLE;
    endcase
  end

`ifdef RALLY_SPEEDUP_EN
  localparam int unsigned RW = (RALLY_STEP > 1) ? $clog2(RALLY_STEP) : 1;
  logic [RW-1:0] rally_cnt;
  logic [31:0]   ticks_dec;

  assign ticks_dec = bus.ai_ticks_per_px - (bus.ai_ticks_per_px >> 3);
`else
  logic unused_paddle_hit;
  assign unused_paddle_hit = bus.paddle_hit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_cnt           <= '0;
      start_q             <= 1'b0;
      diff_q              <= '0;
      bus.game_on         <= 1'b0;
      bus.round_reset     <= 1'b0;
      bus.serve_dir       <= 1'b1;
      bus.score_left      <= '0;
      bus.score_right     <= '0;
      bus.winner          <= '0;
      bus.ai_enable       <= 1'b0;
      bus.ai_ticks_per_px <= 32'(TICKS_EASY);
`ifdef RALLY_SPEEDUP_EN
      rally_cnt           <= '0;
`endif
    end else begin
      start_q         <= bus.start;
      bus.game_on     <= (next_state == PLAY);
      bus.round_reset <= (next_state == SERVE) && (state != SERVE);

      // Shared down-counter: reload on any state change, else count to zero.
      if (next_state != state) begin
        if (next_state == SERVE)      delay_cnt <= DW'(SERVE_DELAY - 1);
        else if (next_state == POINT) delay_cnt <= DW'(POINT_DELAY - 1);
        else                          delay_cnt <= '0;
      end else if (delay_cnt != '0) begin
        delay_cnt <= delay_cnt - 1'b1;
      end

      case (state)
        IDLE, OVER: if (start_rise) begin
          diff_q              <= bus.diff;
          bus.ai_enable       <= (bus.diff != 2'b00);
          bus.ai_ticks_per_px <= ticks_for(bus.diff);
          bus.score_left      <= '0;
          bus.score_right     <= '0;
          bus.winner          <= '0;
        end
        SERVE: begin
          bus.ai_ticks_per_px <= ticks_for(diff_q);
`ifdef RALLY_SPEEDUP_EN
          rally_cnt           <= '0;
`endif
        end
        PLAY: begin
          if (any_miss) begin
            bus.score_left  <= left_next;
            bus.score_right <= right_next;
            if (bus.miss_left && bus.miss_right) bus.serve_dir <= ~bus.serve_dir;
            else                                 bus.serve_dir <= bus.miss_right;
            if (win_left)       bus.winner <= 2'b01;
            else if (win_right) bus.winner <= 2'b10;
          end
`ifdef RALLY_SPEEDUP_EN
          if (bus.paddle_hit) begin
            if (rally_cnt == RW'(RALLY_STEP - 1)) begin
              rally_cnt           <= '0;
              bus.ai_ticks_per_px <= (ticks_dec < 32'(TICKS_MIN)) ? 32'(TICKS_MIN) : ticks_dec;
            end else begin
              rally_cnt <= rally_cnt + 1'b1;
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Top-level Pong match sequencer: runs the serve/play/point/game-over state machine and keeps both scores.
- Drives game_on and a per-round reset pulse to the ball and paddle datapaths.
- Configures the computer-player paddle speed (ticks per pixel) from the latched difficulty.
- Sits between the player start button, the ball engine (miss/hit pulses) and the paddle/computer-player instances.

Parameters:
SERVE_DELAY, 50000000, cycles spent in SERVE before play resumes (>=2)
POINT_DELAY, 25000000, cycles spent in POINT after a score (>=2)
WIN_SCORE, 7, score that ends the match (1..2^SCORE_W-1)
SCORE_W, 4, score counter width
TICKS_EASY, 80000, computer paddle ticks per pixel, diff=01
TICKS_MED, 40000, ticks per pixel, diff=10
TICKS_HARD, 20000, ticks per pixel, diff=11
TICKS_MIN, 10000, floor for rally speed-up
RALLY_STEP, 4, paddle hits per speed-up step

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  start button level, already debounced; rising edge is detected internally
diff  in  2  difficulty: 00 = two-player (computer off), 01 easy, 10 medium, 11 hard
miss_left  in  1  one-cycle pulse: ball passed the left paddle, so right scores
miss_right  in  1  one-cycle pulse: ball passed the right paddle, so left scores
paddle_hit  in  1  one-cycle pulse: ball struck either paddle
game_on  out  1  high only in PLAY
round_reset  out  1  one-cycle pulse re-centring ball and paddles
serve_dir  out  1  0 = serve toward left, 1 = serve toward right
score_left  out  SCORE_W  left score
score_right  out  SCORE_W  right score
winner  out  2  00 none, 01 left, 10 right
ai_enable  out  1  computer player active
ai_ticks_per_px  out  32  computer paddle speed setting
state_dbg  out  3  encoded state: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

Behaviour:
- Reset values (asynchronous, immediate, including mid-operation):
  - state IDLE; game_on 0; round_reset 0; serve_dir 1
  - both scores 0; winner 00; ai_enable 0; ai_ticks_per_px TICKS_EASY
  - delay counter 0; rally counter 0; start edge-detect register 0
- All outputs are registered.
- Start edge: start_rise = start & ~start_q.
- IDLE:
  - start_rise -> SERVE.
  - On that edge: latch diff; ai_enable = (diff != 00); ai_ticks_per_px = table value (00 loads TICKS_EASY, unused); clear scores and winner.
- SERVE:
  - round_reset = 1 exactly on the first cycle in SERVE; 0 otherwise.
  - Occupies exactly SERVE_DELAY cycles, then PLAY.
  - Rally counter cleared; ai_ticks_per_px restored to the latched table value.
- PLAY:
  - game_on = 1 starting on the first cycle in PLAY.
  - miss_left only: score_right += 1; serve_dir = 0.
  - miss_right only: score_left += 1; serve_dir = 1.
  - miss_left and miss_right in the same cycle: no score change; serve_dir toggles; -> POINT.
  - Any miss: if the updated score equals WIN_SCORE -> OVER and winner is set in the same cycle; otherwise -> POINT.
  - game_on falls on the first cycle after the miss.
- POINT:
  - Occupies exactly POINT_DELAY cycles, then SERVE (new round_reset pulse).
- OVER:
  - Scores and winner held; game_on 0.
  - start_rise behaves as in IDLE: relatch diff, clear scores and winner, -> SERVE.
- Inputs ignored outside their states:
  - miss_left, miss_right and paddle_hit are ignored outside PLAY.
  - start is ignored in SERVE, PLAY and POINT.
  - diff changes have no effect until the next start.
- Scores never exceed WIN_SCORE; no wrap is possible.
- Delay counter is a single shared down-counter, reloaded on each state entry.

Optional Feature:
- Macro: RALLY_SPEEDUP_EN.
- Defined:
  - In PLAY, each paddle_hit increments the rally counter.
  - When it reaches RALLY_STEP: it clears, and ai_ticks_per_px -= ai_ticks_per_px>>3, floored at TICKS_MIN. The new value is visible the next cycle.
  - Speed restores at every SERVE.
- Undefined:
  - paddle_hit is unused; no rally counter is built.
  - ai_ticks_per_px stays constant for the whole match.

Test Plan (SERVE_DELAY=4, POINT_DELAY=3, WIN_SCORE=2):
1. reset, then start rise with diff=10 -> round_reset high 1 cycle; ai_enable=1; ai_ticks_per_px=40000; game_on rises exactly 4 cycles after SERVE entry.
2. In PLAY, pulse miss_right -> score_left=1, serve_dir=1, game_on low next cycle; 3 cycles later round_reset pulses; 4 cycles after that game_on=1.
3. Left reaches 2 -> winner=01, state_dbg=4; further miss pulses leave scores unchanged; start rise -> scores 0, winner 00, SERVE.
4. miss_left and miss_right in the same cycle -> scores unchanged, serve_dir toggled, state POINT.
5. Assert reset mid-POINT with score 1-0 -> all outputs at reset values asynchronously, before the next clk edge.
6. With RALLY_SPEEDUP_EN defined and diff=11: 4 hits -> 17500; 8 hits -> 15313; hits continue until the value stays at 10000; next SERVE -> 20000. With the macro undefined: value stays 20000.
